matrix_keypad_scan: RTL and testbench
=====================================

Name: matrix_keypad_scan

Overview:
- Parametrised successor of the two-button player keypad: scans a generic ROWS x COLS passive key matrix and debounces every key independently.
- Exports a full debounced key bitmap plus a single-cycle press-event strobe with the key code.
- Sits between the board GPIO header and game/menu logic. Player up/down controls become plain bit selects of keys.

Parameters:
- ROWS, 4, number of row inputs (1..8)
- COLS, 4, number of column drive outputs (1..8)
- SCAN_DIV, 256, clk cycles each column is driven low; minimum 4
- DEB_FRAMES, 4, consecutive identical samples required to change a key state; minimum 1
- CW, 6, width of press_code; must be >= clog2(ROWS*COLS)

Ports:
- clk  in  1  system clock (25 MHz in the Pong build)
- rst  in  1  synchronous, active-high reset
- col_o  out  COLS  column drive, active-low, at most one bit low
- row_i  in  ROWS  row sense, active-low (external pull-ups), asynchronous
- keys  out  ROWS*COLS  debounced state, 1 = pressed, index = row*COLS+col
- press_valid  out  1  one-cycle pulse on a new press event
- press_code  out  CW  code of the event key, valid only with press_valid
- overrun  out  1  one-cycle pulse when simultaneous events were dropped
- frame_tick  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset values: col_o all ones, keys 0, press_valid 0, press_code 0, overrun 0, frame_tick 0. All counters, column index, debounce and repeat state are cleared.
- Reset is sampled every edge. Reset mid-scan aborts immediately; scanning restarts at column 0, slot cycle 0, on the first edge after rst deasserts.
- row_i passes through a 2-FF synchroniser (reset to all ones = released).
- Column sequencing:
  - A divider counts 0..SCAN_DIV-1.
  - Column c is driven low (col_o = ~(1<<c)) for the whole slot.
  - After the slot, the index advances c -> c+1 and wraps from COLS-1 to 0.
  - A frame is COLS*SCAN_DIV cycles.
- Sample point: divider = SCAN_DIV-1. raw = ~synchronised_row for the current column. This gives at least 2 cycles of settle plus the synchroniser.
- Debounce, per key k in the sampled column, at the sample edge:
  - If raw == keys[k]: cnt[k] <= 0.
  - Else if cnt[k] == DEB_FRAMES-1: keys[k] toggles and cnt[k] <= 0.
  - Else: cnt[k]++.
  - DEB_FRAMES=1 means the state follows raw on every sample.
  - Counter width is clog2(DEB_FRAMES) (minimum 1).
- Press event:
  - A 0->1 transition of keys[k] at a sample edge raises press_valid for exactly the next cycle, with press_code = k.
  - Release (1->0) generates no event.
- Simultaneous presses in the same column/sample: the lowest row wins the event. All keys still update. overrun pulses in the same cycle as press_valid.
- Events from different columns never coincide, because samples are SCAN_DIV >= 4 cycles apart.
- frame_tick pulses in the cycle after the sample of column COLS-1.
- Worst-case press latency from a stable input: 2 sync + DEB_FRAMES frames + 1 cycle.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN
- Defined:
  - Adds parameters REPEAT_DELAY (default 16) and REPEAT_RATE (default 4), both in frames.
  - The last pressed key becomes the tracked key.
  - While it stays pressed, a repeat event (press_valid with the same code) is issued at that key's sample point: first after REPEAT_DELAY samples, then every REPEAT_RATE samples.
  - A new press in the same sample wins and retargets tracking. overrun does not pulse for a suppressed repeat.
  - Release of the tracked key stops repeats.
  - Reset clears tracking.
- Undefined: no repeat logic. Each press generates exactly one event.

Test Plan:
- (ROWS=COLS=4, SCAN_DIV=8, DEB_FRAMES=3; frame = 32 cycles)
- Reset then idle 100 cycles -> col_o walks 1110,1101,1011,0111 (8 cycles each); keys=0; frame_tick every 32 cycles; no press_valid.
- Hold key row2/col1 stably -> keys[9]=1 after exactly the 3rd sample of col1; one press_valid with press_code=9; release -> keys[9]=0 3 frames later, no event.
- Bounce row2/col1: pressed 2 frames, released 1, pressed 3 -> no event until the 3rd consecutive pressed sample; exactly one press_valid, code 9.
- Press keys 4 and 12 (same column 0) in the same cycle -> both keys bits set on the same edge; press_valid with code 4; overrun=1 in that cycle.
- Assert rst for 1 cycle while key 9 is debounced 2/3 -> keys=0, col_o=1111; scan restarts at col0; a full 3-sample debounce is required again.
- With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=2, REPEAT_RATE=1, hold key 5 -> events at press, then +2 frames, then every frame; stops on release.

Source files
------------

// File: rtl/matrix_keypad_scan.sv
// Scans a ROWS x COLS passive key matrix, debounces each key and reports press events.
// Optional auto-repeat of the last pressed key is enabled by defining KEYPAD_AUTOREPEAT_EN.
module matrix_keypad_scan #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 256,
   parameter int DEB_FRAMES = 4,
   parameter int CW         = 6
`ifdef KEYPAD_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 4
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [COLS-1:0]      col_o,
   input  logic [ROWS-1:0]      row_i,
   output logic [ROWS*COLS-1:0] keys,
   output logic                 press_valid,
   output logic [CW-1:0]        press_code,
   output logic                 overrun,
   output logic                 frame_tick
);

   localparam int NK    = ROWS * COLS;
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CNT_W = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_FRAMES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

   logic [ROWS-1:0]  row_p0, row_p1;
   logic             active;
   logic [DIV_W-1:0] div_q, div_nxt;
   logic [COL_W-1:0] col_q, col_nxt;
   logic [CNT_W-1:0] cnt_q [NK];

   logic             sample;
   logic [ROWS-1:0]  raw, cur_key, nxt_key, rise;
   logic [CNT_W-1:0] cur_cnt [ROWS];
   logic [CNT_W-1:0] nxt_cnt [ROWS];

   logic             ev_hit, ev_multi;
   logic [ROW_W-1:0] ev_row;
   logic [CW-1:0]    ev_code;
   logic             rep_hit;
   logic [CW-1:0]    trk_code;

   // Stage p0/p1: row synchroniser, idles at "released"
   always_ff @(posedge clk) begin
      if (rst) begin
         row_p0 <= '1;
         row_p1 <= '1;
      end else begin
         row_p0 <= row_i;
         row_p1 <= row_p0;
      end
   end

   // Scan sequencer; the first edge out of reset only arms it so slot cycle 0 is a full cycle
   always_comb begin
      div_nxt = div_q;
      col_nxt = col_q;
      if (active) begin
         if (div_q == DIV_LAST) begin
            div_nxt = '0;
            col_nxt = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
         end else begin
            div_nxt = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         div_q  <= '0;
         col_q  <= '0;
         col_o  <= '1;
      end else begin
         active <= 1'b1;
         div_q  <= div_nxt;
         col_q  <= col_nxt;
         col_o  <= ~(COLS'(1) << col_nxt);
      end
   end

   assign sample = active && (div_q == DIV_LAST);
   assign raw    = ~row_p1;

   // Debounce step for the keys of the column currently driven
   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         cur_key[r] = 1'b0;
         cur_cnt[r] = '0;
         for (int c = 0; c < COLS; c++) begin
            if (col_q == COL_W'(c)) begin
               cur_key[r] = keys[r*COLS + c];
               cur_cnt[r] = cnt_q[r*COLS + c];
            end
         end
         nxt_key[r] = cur_key[r];
         nxt_cnt[r] = '0;
         if (raw[r] != cur_key[r]) begin
            if (cur_cnt[r] == CNT_MAX)
               nxt_key[r] = ~cur_key[r];
            else
               nxt_cnt[r] = cur_cnt[r] + 1'b1;
         end
         rise[r] = ~cur_key[r] & nxt_key[r];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         keys <= '0;
         for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
      end else if (sample) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if (col_q == COL_W'(c)) begin
                  keys[r*COLS + c]  <= nxt_key[r];
                  cnt_q[r*COLS + c] <= nxt_cnt[r];
               end
            end
         end
      end
   end

   // Lowest row wins; any further rising key in the same sample is an overrun
   always_comb begin
      ev_hit   = 1'b0;
      ev_multi = 1'b0;
      ev_row   = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (rise[r]) begin
            if (ev_hit) begin
               ev_multi = 1'b1;
            end else begin
               ev_hit = 1'b1;
               ev_row = ROW_W'(r);
            end
         end
      end
   end

   assign ev_code = CW'(ev_row) * CW'(COLS) + CW'(col_q);

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic             trk_vld, rep_first, trk_due;
   logic [ROW_W-1:0] trk_row;
   logic [COL_W-1:0] trk_col;
   logic [REP_W-1:0] rep_cnt, rep_tgt;

   assign trk_due  = sample && trk_vld && (col_q == trk_col);
   assign rep_tgt  = rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);
   assign rep_hit  = trk_due && !ev_hit && nxt_key[trk_row] && (rep_cnt + 1'b1 == rep_tgt);
   assign trk_code = CW'(trk_row) * CW'(COLS) + CW'(trk_col);

   // A fresh press always retargets tracking, even when it suppresses a due repeat
   always_ff @(posedge clk) begin
      if (rst) begin
         trk_vld   <= 1'b0;
         rep_first <= 1'b0;
         trk_row   <= '0;
         trk_col   <= '0;
         rep_cnt   <= '0;
      end else if (sample && ev_hit) begin
         trk_vld   <= 1'b1;
         rep_first <= 1'b1;
         trk_row   <= ev_row;
         trk_col   <= col_q;
         rep_cnt   <= '0;
      end else if (trk_due) begin
         if (!nxt_key[trk_row]) begin
            trk_vld <= 1'b0;
         end else if (rep_hit) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end
`else
   assign rep_hit  = 1'b0;
   assign trk_code = '0;
`endif

   // Stage out: event strobes, one cycle after the sample edge
   always_ff @(posedge clk) begin
      if (rst) begin
         press_valid <= 1'b0;
         press_code  <= '0;
         overrun     <= 1'b0;
         frame_tick  <= 1'b0;
      end else begin
         press_valid <= sample && (ev_hit || rep_hit);
         press_code  <= (sample && ev_hit) ? ev_code : (rep_hit ? trk_code : '0);
         overrun     <= sample && ev_multi;
         frame_tick  <= sample && (col_q == COL_LAST);
      end
   end

endmodule

// File: tb/tb_matrix_keypad_scan.sv
// Directed bench for matrix_keypad_scan: 4x4 matrix, SCAN_DIV=8, DEB_FRAMES=3 (32-cycle frame).
module tb_matrix_keypad_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  col_o;
   logic [3:0]  row_i;
   logic [15:0] keys;
   logic        press_valid;
   logic [5:0]  press_code;
   logic        overrun;
   logic        frame_tick;

   logic [15:0] pressed = '0;
   int          n = 0;
   int          evt_cnt = 0;
   int          checks = 0;
   int          errors = 0;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int HOLD_EVTS = 2;
`else
   localparam int HOLD_EVTS = 1;
`endif

   matrix_keypad_scan #(
      .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEB_FRAMES(3), .CW(6)
`ifdef KEYPAD_AUTOREPEAT_EN
      , .REPEAT_DELAY(2), .REPEAT_RATE(1)
`endif
   ) dut (
      .clk(clk), .rst(rst), .col_o(col_o), .row_i(row_i), .keys(keys),
      .press_valid(press_valid), .press_code(press_code),
      .overrun(overrun), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // Edges since reset release: after edge n the DUT drives column ((n-1)/8)%4
   always @(posedge clk) begin
      if (rst) n <= 0;
      else     n <= n + 1;
   end

   always @(posedge clk) begin
      if (press_valid) evt_cnt <= evt_cnt + 1;
   end

   // Passive matrix: a pressed key shorts its row to a low column
   always_comb begin
      row_i = '1;
      for (int c = 0; c < 4; c++)
         if (!col_o[c])
            for (int r = 0; r < 4; r++)
               if (pressed[r*4 + c]) row_i[r] = 1'b0;
   end

   task automatic goto(input int t);
      int guard = 0;
      while (n < t && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (n !== t) begin
         errors++;
         $display("FAIL goto: cycle %0d, required %0d", n, t);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] exp_col;
      logic       exp_ft;
      int         base;
      pressed = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (col_o !== 4'hF) begin errors++; $display("FAIL reset_col: got %h, required f", col_o); end
      checks++; if (keys !== 16'h0) begin errors++; $display("FAIL reset_keys: got %h, required 0", keys); end
      checks++; if (press_valid !== 1'b0 || overrun !== 1'b0 || frame_tick !== 1'b0 || press_code !== 6'd0) begin
         errors++; $display("FAIL reset_strobes: pv=%b ovr=%b ft=%b code=%0d, required all 0", press_valid, overrun, frame_tick, press_code);
      end
      rst = 1'b0;
      base = evt_cnt;
      for (int t = 1; t <= 100; t++) begin
         goto(t);
         exp_col = ~(4'b0001 << (((t - 1) / 8) % 4));
         exp_ft  = (t > 1) && (t % 32 == 1);
         checks++; if (col_o !== exp_col) begin errors++; $display("FAIL idle_col t=%0d: got %b, required %b", t, col_o, exp_col); end
         checks++; if (frame_tick !== exp_ft) begin errors++; $display("FAIL idle_tick t=%0d: got %b, required %b", t, frame_tick, exp_ft); end
         checks++; if (keys !== 16'h0) begin errors++; $display("FAIL idle_keys t=%0d: got %h, required 0", t, keys); end
      end
      checks++; if (evt_cnt - base !== 0) begin errors++; $display("FAIL idle_events: got %0d, required 0", evt_cnt - base); end
   endtask

   task automatic test_hold();
      int base;
      pressed = 16'h0200;
      do_reset();
      base = evt_cnt;
      goto(80);
      checks++; if (keys[9] !== 1'b0) begin errors++; $display("FAIL hold_before: got %b, required 0", keys[9]); end
      goto(81);
      checks++; if (keys !== 16'h0200) begin errors++; $display("FAIL hold_keys: got %h, required 0200", keys); end
      checks++; if (press_valid !== 1'b1) begin errors++; $display("FAIL hold_pv: got %b, required 1", press_valid); end
      checks++; if (press_code !== 6'd9) begin errors++; $display("FAIL hold_code: got %0d, required 9", press_code); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hold_ovr: got %b, required 0", overrun); end
      goto(82);
      checks++; if (press_valid !== 1'b0) begin errors++; $display("FAIL hold_pv_pulse: got %b, required 0", press_valid); end
      goto(90);
      pressed = '0;
      goto(176);
      checks++; if (keys[9] !== 1'b1) begin errors++; $display("FAIL release_before: got %b, required 1", keys[9]); end
      goto(177);
      checks++; if (keys[9] !== 1'b0) begin errors++; $display("FAIL release_keys: got %b, required 0", keys[9]); end
      checks++; if (press_valid !== 1'b0) begin errors++; $display("FAIL release_pv: got %b, required 0", press_valid); end
      goto(180);
      checks++; if (evt_cnt - base !== HOLD_EVTS) begin errors++; $display("FAIL hold_events: got %0d, required %0d", evt_cnt - base, HOLD_EVTS); end
   endtask

   task automatic test_bounce();
      int base;
      pressed = 16'h0200;
      do_reset();
      base = evt_cnt;
      goto(60);
      pressed = '0;
      goto(95);
      pressed = 16'h0200;
      goto(176);
      checks++; if (keys[9] !== 1'b0) begin errors++; $display("FAIL bounce_early: got %b, required 0", keys[9]); end
      checks++; if (evt_cnt - base !== 0) begin errors++; $display("FAIL bounce_no_event: got %0d, required 0", evt_cnt - base); end
      goto(177);
      checks++; if (keys[9] !== 1'b1) begin errors++; $display("FAIL bounce_keys: got %b, required 1", keys[9]); end
      checks++; if (press_valid !== 1'b1 || press_code !== 6'd9) begin
         errors++; $display("FAIL bounce_event: pv=%b code=%0d, required pv=1 code=9", press_valid, press_code);
      end
      pressed = '0;
      goto(180);
      checks++; if (evt_cnt - base !== 1) begin errors++; $display("FAIL bounce_events: got %0d, required 1", evt_cnt - base); end
   endtask

   task automatic test_same_col();
      int base;
      pressed = 16'h1010;
      do_reset();
      base = evt_cnt;
      goto(72);
      checks++; if (keys !== 16'h0) begin errors++; $display("FAIL samecol_before: got %h, required 0", keys); end
      goto(73);
      checks++; if (keys !== 16'h1010) begin errors++; $display("FAIL samecol_keys: got %h, required 1010", keys); end
      checks++; if (press_valid !== 1'b1 || press_code !== 6'd4) begin
         errors++; $display("FAIL samecol_event: pv=%b code=%0d, required pv=1 code=4", press_valid, press_code);
      end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL samecol_ovr: got %b, required 1", overrun); end
      goto(74);
      checks++; if (overrun !== 1'b0 || press_valid !== 1'b0) begin
         errors++; $display("FAIL samecol_pulse: ovr=%b pv=%b, required 0 0", overrun, press_valid);
      end
      pressed = '0;
      goto(80);
      checks++; if (evt_cnt - base !== 1) begin errors++; $display("FAIL samecol_events: got %0d, required 1", evt_cnt - base); end
   endtask

   task automatic test_reset_mid();
      pressed = 16'h0200;
      do_reset();
      goto(60);
      checks++; if (keys !== 16'h0) begin errors++; $display("FAIL mid_pre: got %h, required 0", keys); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (col_o !== 4'hF || keys !== 16'h0) begin
         errors++; $display("FAIL mid_reset: col=%h keys=%h, required f 0", col_o, keys);
      end
      rst = 1'b0;
      goto(1);
      checks++; if (col_o !== 4'b1110) begin errors++; $display("FAIL mid_restart_col: got %b, required 1110", col_o); end
      goto(17);
      checks++; if (keys[9] !== 1'b0) begin errors++; $display("FAIL mid_s1: got %b, required 0", keys[9]); end
      goto(49);
      checks++; if (keys[9] !== 1'b0) begin errors++; $display("FAIL mid_s2: got %b, required 0", keys[9]); end
      goto(81);
      checks++; if (keys[9] !== 1'b1 || press_valid !== 1'b1) begin
         errors++; $display("FAIL mid_s3: key=%b pv=%b, required 1 1", keys[9], press_valid);
      end
      pressed = '0;
   endtask

`ifdef KEYPAD_AUTOREPEAT_EN
   task automatic test_autorepeat();
      int base;
      pressed = 16'h0020;
      do_reset();
      base = evt_cnt;
      goto(81);
      checks++; if (press_valid !== 1'b1 || press_code !== 6'd5) begin
         errors++; $display("FAIL rep_press: pv=%b code=%0d, required 1 5", press_valid, press_code);
      end
      goto(113);
      checks++; if (press_valid !== 1'b0) begin errors++; $display("FAIL rep_wait: got %b, required 0", press_valid); end
      goto(145);
      checks++; if (press_valid !== 1'b1 || press_code !== 6'd5) begin
         errors++; $display("FAIL rep_first: pv=%b code=%0d, required 1 5", press_valid, press_code);
      end
      goto(177);
      checks++; if (press_valid !== 1'b1) begin errors++; $display("FAIL rep_rate1: got %b, required 1", press_valid); end
      goto(209);
      checks++; if (press_valid !== 1'b1) begin errors++; $display("FAIL rep_rate2: got %b, required 1", press_valid); end
      goto(220);
      pressed = '0;
      goto(305);
      checks++; if (press_valid !== 1'b0 || keys[5] !== 1'b0) begin
         errors++; $display("FAIL rep_stop: pv=%b key=%b, required 0 0", press_valid, keys[5]);
      end
      goto(340);
      checks++; if (evt_cnt - base !== 6) begin errors++; $display("FAIL rep_events: got %0d, required 6", evt_cnt - base); end
   endtask
`endif

   initial begin
      test_reset();
      test_hold();
      test_bounce();
      test_same_col();
      test_reset_mid();
`ifdef KEYPAD_AUTOREPEAT_EN
      test_autorepeat();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
